mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Two-port arbiter and sequencer in front of the single-port 256 x 32-bit data memory.
- Shares the memory between requester 0 (instruction fetch) and requester 1 (load/store from the execute stage).
- Grants one requester at a time using round-robin and drives the memory's write-enable, address and write-data inputs.
- Captures the memory's registered read data and returns it to the winning requester with a done pulse.

## Interface
Parameters:
- DEPTH, 256, number of implemented memory words; valid addresses are 0..DEPTH-1.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- r0_req / r1_req  in  1  request; held high until the matching gnt is seen.
- r0_we / r1_we  in  1  1 = write, 0 = read; valid while req is high.
- r0_addr / r1_addr  in  32  word address; valid while req is high.
- r0_wdata / r1_wdata  in  DATA_W  write data; valid while req is high.
- r0_gnt / r1_gnt  out  1  one-cycle pulse: request accepted, inputs latched.
- r0_done / r1_done  out  1  one-cycle pulse: transaction complete.
- r0_rdata / r1_rdata  out  DATA_W  read result; updated only by that requester's completing read.
- r0_err / r1_err  out  1  high together with done when the address was out of range.
- mem_we  out  1  to memory write_enable.
- mem_addr  out  32  to memory address.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_rdata  in  DATA_W  from memory; registered, valid the cycle after the access cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
States:
- IDLE: wait for a request.
- ACCESS: the memory is driven with the latched request.
- CAPTURE: the memory output is sampled.

Transitions:
- IDLE -> ACCESS when any req is high at the posedge. The winner's we/addr/wdata are latched, and the winner's gnt is registered high for exactly the ACCESS cycle.
- ACCESS -> CAPTURE unconditionally. mem_we equals the latched we during ACCESS only and is 0 in every other state. mem_addr and mem_wdata hold the latched values from ACCESS until the next grant.
- CAPTURE -> IDLE unconditionally. At this edge:
  - For a read, the winner's rdata is loaded from mem_rdata.
  - The winner's done is set, lasting the following IDLE cycle.

Arbitration:
- Round-robin. A last-winner pointer updates on each grant.
- When both req are high, the requester that did not win last is granted.
- After reset the pointer favours r0.
- A lone requester always wins.

Out-of-range address (latched addr >= DEPTH):
- The FSM still walks the same three states.
- mem_we is forced to 0.
- rdata is left unchanged.
- err is asserted with done.

Requester rules:
- A requester must drop req in the cycle after it sees gnt.
- req still high in the IDLE cycle carrying done counts as a new request. Back-to-back is legal.

Widths and ordering:
- No address arithmetic; addresses pass through unmodified at 32 bits.
- Writes and reads are completed strictly in grant order; there is no reordering or buffering beyond one in-flight transaction.

## Timing
Reset:
- Asynchronous; applies mid-transaction.
- State becomes IDLE and the pointer favours r0.
- All outputs become 0: gnt, done, err, rdata, mem_we, mem_addr, mem_wdata, busy.
- An in-flight transaction is dropped with no done.
- A write whose ACCESS edge already occurred may have landed in memory.

Cycle-level behaviour, with the request sampled at edge N:
- gnt is high in cycle N+1 (ACCESS).
- The memory performs the operation at edge N+2.
- rdata is loaded and done is set at edge N+3.
- done is visible in cycle N+3.

Throughput and observation:
- Peak throughput is one transaction per 3 cycles.
- busy is high for cycles N+1..N+2.
- gnt and done are never high for both requesters in the same cycle.

## Test plan
- Reset then r0 write addr 5 data 0xDEADBEEF:
  - r0_gnt pulses one cycle later.
  - mem_we=1 for exactly that cycle with mem_addr=5.
  - r0_done pulses 2 cycles after gnt.
  - r0_err=0.
- r1 read addr 5 after the above -> r1_done pulses 3 cycles after req, with r1_rdata=0xDEADBEEF and r0_rdata unchanged.
- r0 and r1 both hold req continuously from reset:
  - Grants alternate r0, r1, r0, r1 every 3 cycles.
  - No cycle has both gnt high or both done high.
- r1 read addr 300 (DEPTH=256):
  - mem_we stays 0 throughout.
  - r1_done and r1_err pulse together 3 cycles after req.
  - r1_rdata is unchanged.
- Assert reset during ACCESS of an r0 read:
  - All outputs are 0 immediately.
  - No r0_done occurs.
  - After release, a new r1 request is granted first with the normal 3-cycle latency.
- r0 keeps req high through its done cycle with r1 idle -> a second r0 grant follows immediately in the cycle after done.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the two requester handshakes and the memory-side bus of mem_arbiter.
//   r0_* : requester 0 (instruction fetch)  req/we/addr/wdata in, gnt/done/rdata/err out
//   r1_* : requester 1 (load/store)         same shape as r0_*
//   mem_*: single-port memory bus           we/addr/wdata out, rdata in (registered)
//   busy : arbiter is not idle
// Modports: slave = arbiter side, master = requesters + memory side.
interface mem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [31:0]       r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_done;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_err;

    logic              r1_req;
    logic              r1_we;
    logic [31:0]       r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_done;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_err;

    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_done, r0_rdata, r0_err,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_done, r1_rdata, r1_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_done, r0_rdata, r0_err,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_done, r1_rdata, r1_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter/sequencer sharing one single-port DEPTH x DATA_W memory
// between requester 0 and requester 1. One transaction in flight at a time,
// three cycles per transaction (ACCESS, CAPTURE, then IDLE carrying done).
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous, active-high
//   bus   : mem_arbiter_if.slave (requester handshakes, memory bus, busy)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; done/err of the previous txn shown here
// ACCESS  | memory driven with latched request; gnt high, mem_we may be high
// CAPTURE | registered memory read data is valid and sampled at exit edge
module mem_arbiter #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t            state;
    state_t            next_state;

    logic              start;
    logic              win;        // 0 = r0, 1 = r1
    logic              last_win;   // reset to 1 so r0 is favoured first
    logic              sel;        // winner of the in-flight transaction
    logic              lat_we;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              in_range;

    logic              gnt0_q, gnt1_q;
    logic              done0_q, done1_q;
    logic              err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    assign in_range = (addr_q < DEPTH_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        win        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.r0_req || bus.r1_req) begin
                    start      = 1'b1;
                    next_state = ACCESS;
                    if (bus.r0_req && bus.r1_req) begin
                        win = ~last_win;
                    end else begin
                        win = bus.r1_req;
                    end
                end
            end
            ACCESS:  next_state = CAPTURE;
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_win <= 1'b1;
            sel      <= 1'b0;
            lat_we   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            gnt0_q  <= start & ~win;
            gnt1_q  <= start & win;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;

            if (start) begin
                last_win <= win;
                sel      <= win;
                lat_we   <= win ? bus.r1_we    : bus.r0_we;
                addr_q   <= win ? bus.r1_addr  : bus.r0_addr;
                wdata_q  <= win ? bus.r1_wdata : bus.r0_wdata;
            end

            // Completion: rdata only moves on an in-range read.
            if (state == CAPTURE) begin
                if (sel) begin
                    done1_q <= 1'b1;
                    err1_q  <= ~in_range;
                    if (in_range && !lat_we) begin
                        rdata1_q <= bus.mem_rdata;
                    end
                end else begin
                    done0_q <= 1'b1;
                    err0_q  <= ~in_range;
                    if (in_range && !lat_we) begin
                        rdata0_q <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    // Out-of-range writes are suppressed here so the memory never aliases them.
    assign bus.mem_we    = (state == ACCESS) && lat_we && in_range;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state != IDLE);

    assign bus.r0_gnt   = gnt0_q;
    assign bus.r1_gnt   = gnt1_q;
    assign bus.r0_done  = done0_q;
    assign bus.r1_done  = done1_q;
    assign bus.r0_err   = err0_q;
    assign bus.r1_err   = err1_q;
    assign bus.r0_rdata = rdata0_q;
    assign bus.r1_rdata = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: models the registered 256-word memory,
// drives both requesters and checks completions through a scoreboard queue.
module tb_mem_arbiter;
    logic clk;
    logic reset;

    mem_arbiter_if #(.DATA_W(32)) bus();

    mem_arbiter #(.DEPTH(256), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read single-port memory, indexed by the low 8 address bits.
    logic [31:0] tb_mem [256];
    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        bus.mem_rdata <= tb_mem[bus.mem_addr[7:0]];
    end

    typedef struct {
        logic        port;
        logic        err;
        logic        is_read;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    // Scoreboard: every done pulse pops the oldest expected completion.
    always @(negedge clk) begin
        if (!reset && (bus.r0_done || bus.r1_done)) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_done: got done r0=%b r1=%b, want no done", bus.r0_done, bus.r1_done);
            end else begin
                mon_e = sb.pop_front();
                if ((bus.r1_done !== mon_e.port) ||
                    ((mon_e.port ? bus.r1_err : bus.r0_err) !== mon_e.err) ||
                    (mon_e.is_read && ((mon_e.port ? bus.r1_rdata : bus.r0_rdata) !== mon_e.rdata))) begin
                    $display("FAIL sb_done: got port=%b err=%b rdata=%h, want port=%b err=%b rdata=%h (read=%b)",
                             bus.r1_done, mon_e.port ? bus.r1_err : bus.r0_err,
                             mon_e.port ? bus.r1_rdata : bus.r0_rdata,
                             mon_e.port, mon_e.err, mon_e.rdata, mon_e.is_read);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        if (!port) begin
            bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = data;
        end else begin
            bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = data;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        n_total++;
        if ({bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err, bus.mem_we, bus.busy} !== 8'h00) begin
            $display("FAIL reset_flags: got %b want 00000000",
                     {bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err, bus.mem_we, bus.busy});
        end else n_pass++;
        n_total++;
        if ({bus.r0_rdata, bus.r1_rdata, bus.mem_addr, bus.mem_wdata} !== 128'h0) begin
            $display("FAIL reset_data: got %h %h %h %h want all 0", bus.r0_rdata, bus.r1_rdata, bus.mem_addr, bus.mem_wdata);
        end else n_pass++;
        reset = 1'b0;
        tick();
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_write();
        drive(0, 1, 1, 32'd5, 32'hDEADBEEF);
        sb.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
        tick();
        n_total++;
        if ({bus.r0_gnt, bus.r1_gnt, bus.mem_we, bus.busy} !== 4'b1011)
            $display("FAIL write_access: got gnt0/gnt1/we/busy=%b want 1011", {bus.r0_gnt, bus.r1_gnt, bus.mem_we, bus.busy});
        else n_pass++;
        n_total++;
        if (bus.mem_addr !== 32'd5 || bus.mem_wdata !== 32'hDEADBEEF)
            $display("FAIL write_bus: got addr=%h wdata=%h want 5 deadbeef", bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        drive(0, 0, 0, 32'd0, 32'd0);
        tick();
        n_total++;
        if ({bus.r0_gnt, bus.mem_we, bus.busy, bus.r0_done} !== 4'b0010)
            $display("FAIL write_capture: got gnt0/we/busy/done0=%b want 0010", {bus.r0_gnt, bus.mem_we, bus.busy, bus.r0_done});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.r0_done, bus.r0_err, bus.busy} !== 3'b100)
            $display("FAIL write_done: got done0/err0/busy=%b want 100", {bus.r0_done, bus.r0_err, bus.busy});
        else n_pass++;
        tick();
        n_total++;
        if (bus.r0_done !== 1'b0) $display("FAIL write_done_width: got %b want 0", bus.r0_done);
        else n_pass++;
    endtask

    task automatic test_read();
        drive(1, 1, 0, 32'd5, 32'd0);
        sb.push_back('{1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
        tick();
        n_total++;
        if ({bus.r1_gnt, bus.r0_gnt, bus.mem_we} !== 3'b100)
            $display("FAIL read_gnt: got gnt1/gnt0/we=%b want 100", {bus.r1_gnt, bus.r0_gnt, bus.mem_we});
        else n_pass++;
        drive(1, 0, 0, 32'd0, 32'd0);
        tick();
        n_total++;
        if (bus.r1_done !== 1'b0) $display("FAIL read_early_done: got %b want 0", bus.r1_done);
        else n_pass++;
        tick();
        n_total++;
        if (bus.r1_done !== 1'b1 || bus.r1_rdata !== 32'hDEADBEEF || bus.r0_rdata !== 32'h0)
            $display("FAIL read_done: got done1=%b rdata1=%h rdata0=%h want 1 deadbeef 0", bus.r1_done, bus.r1_rdata, bus.r0_rdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_out_of_range();
        logic any_we;
        any_we = 1'b0;
        drive(1, 1, 0, 32'd300, 32'd0);
        sb.push_back('{1'b1, 1'b1, 1'b1, 32'hDEADBEEF});
        for (int i = 1; i <= 3; i++) begin
            tick();
            any_we |= bus.mem_we;
            if (i == 1) begin
                n_total++;
                if (bus.mem_addr !== 32'd300) $display("FAIL oor_addr_pass: got %h want 12c", bus.mem_addr);
                else n_pass++;
                drive(1, 0, 0, 32'd0, 32'd0);
            end
        end
        n_total++;
        if ({bus.r1_done, bus.r1_err} !== 2'b11 || bus.r1_rdata !== 32'hDEADBEEF)
            $display("FAIL oor_read_done: got done1/err1=%b rdata1=%h want 11 deadbeef", {bus.r1_done, bus.r1_err}, bus.r1_rdata);
        else n_pass++;
        tick();

        drive(0, 1, 1, 32'd256, 32'h12345678);
        sb.push_back('{1'b0, 1'b1, 1'b0, 32'h0});
        for (int i = 1; i <= 3; i++) begin
            tick();
            any_we |= bus.mem_we;
            if (i == 1) drive(0, 0, 0, 32'd0, 32'd0);
        end
        n_total++;
        if (any_we !== 1'b0) $display("FAIL oor_mem_we: got %b want 0", any_we);
        else n_pass++;
        tick();

        drive(0, 1, 0, 32'd0, 32'd0);
        sb.push_back('{1'b0, 1'b0, 1'b1, 32'h0});
        tick();
        drive(0, 0, 0, 32'd0, 32'd0);
        tick();
        tick();
        n_total++;
        if (bus.r0_rdata !== 32'h0) $display("FAIL oor_no_alias: got %h want 0", bus.r0_rdata);
        else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        int bad;
        logic both;
        logic [1:0] want;
        bad  = 0;
        both = 1'b0;
        pulse_reset();
        drive(0, 1, 0, 32'd5, 32'd0);
        drive(1, 1, 0, 32'd16, 32'd0);
        sb.push_back('{1'b0, 1'b0, 1'b1, 32'hDEADBEEF});
        sb.push_back('{1'b1, 1'b0, 1'b1, 32'h0});
        sb.push_back('{1'b0, 1'b0, 1'b1, 32'hDEADBEEF});
        sb.push_back('{1'b1, 1'b0, 1'b1, 32'h0});
        for (int i = 1; i <= 12; i++) begin
            tick();
            if ((bus.r0_gnt && bus.r1_gnt) || (bus.r0_done && bus.r1_done)) both = 1'b1;
            want = 2'b00;
            if (i == 1 || i == 7)  want = 2'b01;
            if (i == 4 || i == 10) want = 2'b10;
            if ({bus.r1_gnt, bus.r0_gnt} !== want) begin
                bad++;
                $display("FAIL rr_gnt_cycle%0d: got gnt1/gnt0=%b want %b", i, {bus.r1_gnt, bus.r0_gnt}, want);
            end
        end
        drive(0, 0, 0, 32'd0, 32'd0);
        drive(1, 0, 0, 32'd0, 32'd0);
        n_total++;
        if (bad !== 0) $display("FAIL rr_sequence: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_total++;
        if (both !== 1'b0) $display("FAIL rr_exclusive: got both-high=%b want 0", both);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.busy, bus.r0_gnt, bus.r1_gnt} !== 3'b000)
            $display("FAIL rr_quiet: got busy/gnt0/gnt1=%b want 000", {bus.busy, bus.r0_gnt, bus.r1_gnt});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic saw0;
        saw0 = 1'b0;
        drive(0, 1, 0, 32'd5, 32'd0);
        tick();
        n_total++;
        if (bus.r0_gnt !== 1'b1) $display("FAIL rstmid_gnt: got %b want 1", bus.r0_gnt);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err, bus.mem_we, bus.busy} !== 8'h00 ||
            {bus.r0_rdata, bus.r1_rdata, bus.mem_addr, bus.mem_wdata} !== 128'h0)
            $display("FAIL rstmid_outputs: got flags=%b rdata0=%h rdata1=%h addr=%h wdata=%h want all 0",
                     {bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done, bus.r0_err, bus.r1_err, bus.mem_we, bus.busy},
                     bus.r0_rdata, bus.r1_rdata, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        drive(0, 0, 0, 32'd0, 32'd0);
        tick();
        saw0 |= bus.r0_done;
        tick();
        saw0 |= bus.r0_done;
        reset = 1'b0;
        drive(1, 1, 0, 32'd5, 32'd0);
        sb.push_back('{1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
        for (int i = 1; i <= 4; i++) begin
            tick();
            saw0 |= bus.r0_done;
            if (i == 1) begin
                n_total++;
                if ({bus.r1_gnt, bus.r0_gnt} !== 2'b10) $display("FAIL rstmid_r1_gnt: got gnt1/gnt0=%b want 10", {bus.r1_gnt, bus.r0_gnt});
                else n_pass++;
                drive(1, 0, 0, 32'd0, 32'd0);
            end
            if (i == 3) begin
                n_total++;
                if (bus.r1_done !== 1'b1) $display("FAIL rstmid_r1_done: got %b want 1", bus.r1_done);
                else n_pass++;
            end
        end
        n_total++;
        if (saw0 !== 1'b0) $display("FAIL rstmid_dropped: got r0_done seen=%b want 0", saw0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 1, 32'd7, 32'hA5A50F0F);
        sb.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
        tick();
        tick();
        tick();
        n_total++;
        if ({bus.r0_done, bus.r0_gnt} !== 2'b10) $display("FAIL b2b_first_done: got done0/gnt0=%b want 10", {bus.r0_done, bus.r0_gnt});
        else n_pass++;
        drive(0, 1, 0, 32'd7, 32'd0);
        sb.push_back('{1'b0, 1'b0, 1'b1, 32'hA5A50F0F});
        tick();
        n_total++;
        if ({bus.r0_gnt, bus.r0_done, bus.mem_we} !== 3'b100)
            $display("FAIL b2b_second_gnt: got gnt0/done0/we=%b want 100", {bus.r0_gnt, bus.r0_done, bus.mem_we});
        else n_pass++;
        drive(0, 0, 0, 32'd0, 32'd0);
        tick();
        tick();
        n_total++;
        if (bus.r0_done !== 1'b1 || bus.r0_rdata !== 32'hA5A50F0F)
            $display("FAIL b2b_second_done: got done0=%b rdata0=%h want 1 a5a50f0f", bus.r0_done, bus.r0_rdata);
        else n_pass++;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        reset = 1'b1;
        drive(0, 0, 0, 32'd0, 32'd0);
        drive(1, 0, 0, 32'd0, 32'd0);

        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_round_robin();
        test_reset_mid();
        test_back_to_back();

        tick();
        tick();
        n_total++;
        if (sb.size() !== 0) $display("FAIL sb_drained: got %0d pending want 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
